mb2ip_regbank: RTL

- Parametrised slave endpoint for the MB2IP/IP2MB register bus that the MicroBlaze subsystem exports to fabric logic such as the SATA test logic.
- Replaces hand-decoded single-chip-select handshakes with a generic bank: NUM_CS regions of NUM_REGS words each.
- Each region is read/write control or read-only status, selected by RO_MASK.
- Provides configurable ack latency, byte-enable writes, write strobes, and error responses for illegal accesses.

---
 rtl/mb2ip_regbank_pkg.sv | 24 ++
 rtl/mb2ip_regbank_if.sv | 26 ++
 rtl/mb2ip_regbank_reg_word.sv | 22 ++
 rtl/mb2ip_regbank.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mb2ip_regbank_pkg.sv
// Shared types and helpers for the MB2IP register bank.
package mb2ip_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

    // Ceiling log2, never less than 1 so index fields stay at least one bit wide.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Bit offset of word (c,i) inside a flattened region/word bus.
    function automatic int word_off(input int c, input int i, input int nregs, input int dw);
        return (c * nregs + i) * dw;
    endfunction

    // True when exactly one bit is set; chip-select vectors are at most 8 wide.
    function automatic logic onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/mb2ip_regbank_if.sv
// MB2IP/IP2MB register bus as seen between the MicroBlaze bridge and a slave.
interface mb2ip_regbank_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NUM_CS = 2
);
    logic [NUM_CS-1:0]   MB2IP_CS;
    logic                MB2IP_RNW;
    logic [ADDR_W-1:0]   MB2IP_Addr;
    logic [DATA_W-1:0]   MB2IP_Data;
    logic [DATA_W/8-1:0] MB2IP_BE;
    logic [DATA_W-1:0]   IP2MB_Data;
    logic                IP2MB_RdAck;
    logic                IP2MB_WrAck;
    logic                IP2MB_Error;

    modport master (
        output MB2IP_CS, MB2IP_RNW, MB2IP_Addr, MB2IP_Data, MB2IP_BE,
        input  IP2MB_Data, IP2MB_RdAck, IP2MB_WrAck, IP2MB_Error
    );

    modport slave (
        input  MB2IP_CS, MB2IP_RNW, MB2IP_Addr, MB2IP_Data, MB2IP_BE,
        output IP2MB_Data, IP2MB_RdAck, IP2MB_WrAck, IP2MB_Error
    );
endinterface

// File: rtl/mb2ip_regbank_reg_word.sv
// One byte-enabled control word with asynchronous reset to a fixed value.
module mb2ip_reg_word #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   d,
    output logic [DATA_W-1:0]   q
);
    // Merge enabled bytes of d into the stored word on a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (we) begin
            for (int k = 0; k < DATA_W / 8; k++)
                if (be[k]) q[8*k +: 8] <= d[8*k +: 8];
        end
    end
endmodule

// File: rtl/mb2ip_regbank.sv
// Generic MB2IP slave: NUM_CS regions of NUM_REGS words, control or status per region.
module mb2ip_regbank
    import mb2ip_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                NUM_CS   = 2,
    parameter int                NUM_REGS = 8,
    parameter int                BASE_LSB = 2,
    parameter int                ACK_LAT  = 1,
    parameter logic [7:0]        RO_MASK  = 8'b10,
    parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
    input  logic                                MB2IP_Clk,
    input  logic                                MB2IP_Reset,
    mb2ip_regbank_if.slave                      bus,
    output logic [NUM_CS*NUM_REGS*DATA_W-1:0]   ctrl_q,
    output logic [NUM_CS*NUM_REGS-1:0]          wr_stb,
    input  logic [NUM_CS*NUM_REGS*DATA_W-1:0]   status_i
);
    localparam int IDX_W = clog2(NUM_REGS);
    localparam int CS_W  = clog2(NUM_CS);
    localparam int BE_W  = DATA_W / 8;
    localparam int NW    = NUM_CS * NUM_REGS;

    state_t              state;
    logic [3:0]          cnt_q;
    logic [CS_W-1:0]     region_q, live_region, cur_region;
    logic [IDX_W-1:0]    idx_q, live_idx, cur_idx;
    logic                rnw_q, err_q, live_err, cur_rnw, cur_err;
    logic [DATA_W-1:0]   data_q, cur_data, rd_word, rd_data;
    logic [BE_W-1:0]     be_q, cur_be;
    logic                any_cs, go_ack, rd_ack, wr_ack, err_out;
    logic [NW-1:0]       wr_en;
    int                  cur_word;

    assign any_cs   = |bus.MB2IP_CS;
    assign live_idx = bus.MB2IP_Addr[BASE_LSB +: IDX_W];

    // Decode the live request: lowest selected region and the error conditions.
    always_comb begin
        live_region = '0;
        for (int c = NUM_CS - 1; c >= 0; c--)
            if (bus.MB2IP_CS[c]) live_region = CS_W'(c);
        live_err = !onehot8(8'(bus.MB2IP_CS))
                || (int'(live_idx) >= NUM_REGS)
                || ((bus.MB2IP_Addr & ADDR_W'((1 << BASE_LSB) - 1)) != '0)
                || (!bus.MB2IP_RNW && RO_MASK[live_region]);
    end

    // With ACK_LAT=1 the ack is issued straight from IDLE, so use the live
    // request there and the latched copy once the FSM has moved on.
    always_comb begin
        if (state == IDLE) begin
            cur_region = live_region;
            cur_idx    = live_idx;
            cur_rnw    = bus.MB2IP_RNW;
            cur_err    = live_err;
            cur_data   = bus.MB2IP_Data;
            cur_be     = bus.MB2IP_BE;
        end else begin
            cur_region = region_q;
            cur_idx    = idx_q;
            cur_rnw    = rnw_q;
            cur_err    = err_q;
            cur_data   = data_q;
            cur_be     = be_q;
        end
        // Errored accesses never touch a word, so pin the index in range.
        cur_word = cur_err ? 0 : int'(cur_region) * NUM_REGS + int'(cur_idx);
        go_ack   = any_cs && (((state == IDLE) && (ACK_LAT == 1)) ||
                              ((state == WAIT) && (cnt_q == 4'd1)));
        rd_word  = RO_MASK[cur_region] ? status_i[word_off(int'(cur_region), int'(cur_idx), NUM_REGS, DATA_W) +: DATA_W]
                                       : ctrl_q[word_off(int'(cur_region), int'(cur_idx), NUM_REGS, DATA_W) +: DATA_W];
        for (int w = 0; w < NW; w++)
            wr_en[w] = go_ack && !cur_rnw && !cur_err && (cur_word == w);
    end

    // Transaction FSM with registered ack, error, read data and write strobes.
    always_ff @(posedge MB2IP_Clk or posedge MB2IP_Reset) begin
        if (MB2IP_Reset) begin
            state    <= IDLE;
            cnt_q    <= '0;
            region_q <= '0;
            idx_q    <= '0;
            rnw_q    <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
            be_q     <= '0;
            rd_ack   <= 1'b0;
            wr_ack   <= 1'b0;
            err_out  <= 1'b0;
            rd_data  <= '0;
            wr_stb   <= '0;
        end else begin
            rd_ack  <= go_ack && cur_rnw;
            wr_ack  <= go_ack && !cur_rnw;
            err_out <= go_ack && cur_err;
            rd_data <= (go_ack && cur_rnw && !cur_err) ? rd_word : '0;
            wr_stb  <= wr_en;
            case (state)
                IDLE: if (any_cs) begin
                    region_q <= live_region;
                    idx_q    <= live_idx;
                    rnw_q    <= bus.MB2IP_RNW;
                    err_q    <= live_err;
                    data_q   <= bus.MB2IP_Data;
                    be_q     <= bus.MB2IP_BE;
                    if (ACK_LAT == 1) begin
                        state <= ACK;
                    end else begin
                        state <= WAIT;
                        cnt_q <= 4'(ACK_LAT - 1);
                    end
                end
                WAIT: begin
                    if (!any_cs)             state <= IDLE;
                    else if (cnt_q == 4'd1)  state <= ACK;
                    else                     cnt_q <= cnt_q - 4'd1;
                end
                ACK:  state <= HOLD;
                HOLD: if (!any_cs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.IP2MB_RdAck = rd_ack;
    assign bus.IP2MB_WrAck = wr_ack;
    assign bus.IP2MB_Error = err_out;
    assign bus.IP2MB_Data  = rd_data;

    // Control words for RW regions; RO regions expose zero on ctrl_q.
    for (genvar c = 0; c < NUM_CS; c++) begin : g_cs
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
            localparam int W = c * NUM_REGS + i;
            if (RO_MASK[c]) begin : g_ro
                assign ctrl_q[W*DATA_W +: DATA_W] = '0;
            end else begin : g_rw
                mb2ip_reg_word #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_word (
                    .clk (MB2IP_Clk),
                    .rst (MB2IP_Reset),
                    .we  (wr_en[W]),
                    .be  (cur_be),
                    .d   (cur_data),
                    .q   (ctrl_q[W*DATA_W +: DATA_W])
                );
            end
        end
    end
endmodule
